// File: rtl/wash_key_ctrl_if.sv
// rtl/wash_key_ctrl_if.sv - raw key inputs and decoded control outputs of the washer key panel
interface wash_key_ctrl_if;
  logic key_add;
  logic key_start;
  logic key_emg;
  logic key_clr;
  logic add;
  logic clr;
  logic start;
  logic emergency;

  modport master (
    output key_add, key_start, key_emg, key_clr,
    input  add, clr, start, emergency
  );

  modport slave (
    input  key_add, key_start, key_emg, key_clr,
    output add, clr, start, emergency
  );
endinterface

// File: rtl/wash_key_ctrl.sv
// rtl/wash_key_ctrl.sv - four-key debouncer and washer control decoder; KEY_AUTOREPEAT_EN enables add auto-repeat
module wash_key_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 12500000
) (
  input logic             CLK_50,
  input logic             nCLR,
  wash_key_ctrl_if.slave  kif
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

  // key index: 0 add, 1 start, 2 emergency, 3 clear
  localparam int K_ADD = 0;
  localparam int K_STA = 1;
  localparam int K_EMG = 2;
  localparam int K_CLR = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } deb_state_e;

  logic [3:0]    raw_keys;
  logic [3:0]    sync1_q, sync2_q;
  deb_state_e    st_q  [4];
  deb_state_e    st_d  [4];
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    press_ev;

  logic add_q, add_d;
  logic clr_q, clr_d;
  logic start_q, start_d;
  logic emg_q, emg_d;
  logic add_ev;

  assign raw_keys = {kif.key_clr, kif.key_emg, kif.key_start, kif.key_add};

  // per-key debounce FSM: a level must stay stable for DEB_CYCLES clocks to be accepted
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_d[i]     = st_q[i];
      cnt_d[i]    = cnt_q[i];
      press_ev[i] = 1'b0;
      case (st_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            st_d[i]  = DEB_PRESS;
            cnt_d[i] = '0;
          end
        end
        DEB_PRESS: begin
          if (!sync2_q[i]) begin
            st_d[i] = IDLE;
          end else if (cnt_q[i] == DEB_MAX) begin
            st_d[i]     = HELD;
            press_ev[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            st_d[i]  = DEB_REL;
            cnt_d[i] = '0;
          end
        end
        DEB_REL: begin
          if (sync2_q[i]) begin
            st_d[i] = HELD;
          end else if (cnt_q[i] == DEB_MAX) begin
            st_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          st_d[i]  = IDLE;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  logic [24:0] rpt_q, rpt_d;
  logic        rpt_first_q, rpt_first_d;
  logic        rpt_fire;

  // add repeat timer: first pulse after RPT_DELAY, later ones every RPT_PERIOD while held
  always_comb begin
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if (st_q[K_ADD] == HELD && st_d[K_ADD] == HELD) begin
      if (rpt_q == (rpt_first_q ? 25'(RPT_PERIOD - 1) : 25'(RPT_DELAY - 1))) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_first_d = 1'b1;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end else begin
      rpt_d       = '0;
      rpt_first_d = 1'b0;
    end
  end

  // repeat timer state
  always_ff @(posedge CLK_50 or negedge nCLR) begin
    if (!nCLR) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign add_ev = press_ev[K_ADD] | rpt_fire;
`else
  assign add_ev = press_ev[K_ADD];
`endif

  // output decode: clear beats add, start beats emergency, start falling drops emergency
  always_comb begin
    clr_d   = press_ev[K_CLR];
    add_d   = add_ev & ~press_ev[K_CLR];
    start_d = start_q ^ press_ev[K_STA];
    emg_d   = emg_q;
    if (press_ev[K_STA]) begin
      if (start_q) emg_d = 1'b0;
    end else if (press_ev[K_EMG] && start_q) begin
      emg_d = ~emg_q;
    end
  end

  // synchronizers, debouncer state and registered outputs
  always_ff @(posedge CLK_50 or negedge nCLR) begin
    if (!nCLR) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
      add_q   <= 1'b0;
      clr_q   <= 1'b0;
      start_q <= 1'b0;
      emg_q   <= 1'b0;
    end else begin
      sync1_q <= raw_keys;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      add_q   <= add_d;
      clr_q   <= clr_d;
      start_q <= start_d;
      emg_q   <= emg_d;
    end
  end

  assign kif.add       = add_q;
  assign kif.clr       = clr_q;
  assign kif.start     = start_q;
  assign kif.emergency = emg_q;

endmodule

// File: tb/tb_wash_key_ctrl.sv
// tb/tb_wash_key_ctrl.sv - directed bench for wash_key_ctrl with DEB_CYCLES=4
module tb_wash_key_ctrl;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;

  wash_key_ctrl_if kif ();

  wash_key_ctrl #(
    .DEB_CYCLES (4),
    .RPT_DELAY  (20),
    .RPT_PERIOD (8)
  ) dut (
    .CLK_50 (clk),
    .nCLR   (rst_n),
    .kif    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    kif.key_add   = 1'b0;
    kif.key_start = 1'b0;
    kif.key_emg   = 1'b0;
    kif.key_clr   = 1'b0;
    @(negedge clk);
    ticks(3);
    chk("rst_add",   kif.add,       1'b0);
    chk("rst_clr",   kif.clr,       1'b0);
    chk("rst_start", kif.start,     1'b0);
    chk("rst_emg",   kif.emergency, 1'b0);
    rst_n = 1'b1;
    ticks(3);

    // short press of 3 clocks is rejected
    kif.key_add = 1'b1;
    ticks(3);
    kif.key_add = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("short_add", kif.add, 1'b0);
    end

    // clean 30-clock hold: single pulse at cycle 7
    kif.key_add = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
`ifdef KEY_AUTOREPEAT_EN
      chk("hold_add", kif.add, (c == 7) || (c == 27));
`else
      chk("hold_add", kif.add, c == 7);
`endif
    end
    kif.key_add = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("release_add", kif.add, 1'b0);
    end

    // add and clr together: clr wins
    kif.key_add = 1'b1;
    kif.key_clr = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("both_clr", kif.clr, c == 7);
      chk("both_add", kif.add, 1'b0);
    end
    kif.key_add = 1'b0;
    kif.key_clr = 1'b0;
    ticks(15);
    chk("both_rel_clr", kif.clr, 1'b0);

    // bounce 1,0,1,0 then hold: one pulse 7 clocks after final rise
    kif.key_add = 1'b1; tick();
    kif.key_add = 1'b0; tick();
    kif.key_add = 1'b1; tick();
    kif.key_add = 1'b0; tick();
    kif.key_add = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("bounce_add", kif.add, c == 7);
    end
    kif.key_add = 1'b0;
    ticks(15);

    // emergency ignored while stopped
    kif.key_emg = 1'b1;
    ticks(10);
    chk("emg_idle", kif.emergency, 1'b0);
    kif.key_emg = 1'b0;
    ticks(12);

    // start -> emergency -> start
    kif.key_start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("start_on", kif.start, c >= 7);
    end
    kif.key_start = 1'b0;
    ticks(12);
    kif.key_emg = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("emg_on", kif.emergency, c >= 7);
    end
    kif.key_emg = 1'b0;
    ticks(12);
    chk("emg_kept", kif.emergency, 1'b1);
    kif.key_start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("start_off", kif.start, c < 7);
      chk("emg_forced", kif.emergency, c < 7);
    end
    kif.key_start = 1'b0;
    ticks(12);

    // start and emergency in the same clock: only start applies
    kif.key_start = 1'b1;
    kif.key_emg   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("same_start", kif.start, c >= 7);
      chk("same_emg", kif.emergency, 1'b0);
    end
    kif.key_start = 1'b0;
    kif.key_emg   = 1'b0;
    ticks(12);

    // reset mid-debounce while start key held
    kif.key_start = 1'b1;
    ticks(5);
    rst_n = 1'b0;
    ticks(2);
    chk("rst_mid_start", kif.start, 1'b0);
    chk("rst_mid_emg", kif.emergency, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("rst_repress", kif.start, c >= 7);
    end
    kif.key_start = 1'b0;
    ticks(12);
    chk("final_start", kif.start, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/wash_key_ctrl.md
WASH_KEY_CTRL -- requirements
Module: wash_key_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, consecutive stable clocks required to accept a key level change (20 ms at 50 MHz).
REQ-002 Parameter RPT_DELAY, default 25000000, hold time before the first auto-repeat pulse.
REQ-003 Parameter RPT_PERIOD, default 12500000, interval between later auto-repeat pulses.
REQ-004 CLK_50  in  1  system clock, 50 MHz; one clock domain only.
REQ-005 nCLR  in  1  reset, asynchronous assert, active-low.
REQ-006 key_add, key_start, key_emg, key_clr  in  1 each  raw mechanical push-buttons, active-high, asynchronous, bouncing.
REQ-007 add  out  1  one-clock pulse per accepted add press; feeds the loop-count input of the washer controller.
REQ-008 clr  out  1  one-clock pulse per accepted clear press.
REQ-009 start  out  1  run level; toggles on each accepted start press.
REQ-010 emergency  out  1  pause level; toggles on each accepted emergency press.

Function
REQ-011 Each raw key SHALL pass through its own two-flop synchronizer before any other logic.
REQ-012 Each key SHALL run an independent debouncer with four states: IDLE, DEB_PRESS, HELD, DEB_REL.
  - IDLE: a synchronized 1 moves to DEB_PRESS and clears the counter.
  - DEB_PRESS: increments while the input is 1; a 0 returns to IDLE; reaching DEB_CYCLES moves to HELD and raises the press event.
  - HELD: a 0 moves to DEB_REL and clears the counter.
  - DEB_REL: increments while the input is 0; a 1 returns to HELD; reaching DEB_CYCLES moves to IDLE.
REQ-013 The counter width SHALL be $clog2(DEB_CYCLES+1); the counter SHALL saturate and never wrap.
REQ-014 Latency from a raw edge held stable to the press event SHALL be exactly 2 + DEB_CYCLES + 1 clocks, and add/clr SHALL assert in that cycle.
REQ-015 A bounce shorter than DEB_CYCLES SHALL produce no event in either direction.
REQ-016 add and clr SHALL each be high for exactly one clock per event, and there SHALL be no event on release.
REQ-017 start SHALL invert on each start press event.
REQ-018 emergency SHALL invert on each emergency press event, but only while start is 1.
REQ-019 When start falls, emergency SHALL be forced to 0 in the same clock.
REQ-020 If add and clr events occur in the same clock, clr SHALL pulse and add SHALL be suppressed.
REQ-021 If start and emergency events occur in the same clock, only the start toggle SHALL apply.
REQ-022 Events on different keys in different clocks SHALL never be lost or merged.

Reset
REQ-023 While nCLR is 0, all outputs SHALL be 0, all debouncers SHALL be in IDLE, counters and synchronizers SHALL be 0, and any debounce in progress SHALL be discarded.
REQ-024 After nCLR releases, a key already held SHALL be treated as a new press, with full debounce latency.

Configuration
REQ-025 Macro KEY_AUTOREPEAT_EN.
  - Defined: while key_add stays in HELD, add SHALL pulse again RPT_DELAY clocks after the press event, then every RPT_PERIOD clocks until release. The repeat timer SHALL be 25 bits and clear on leaving HELD.
  - Undefined: no repeat logic or timer SHALL be present, and add SHALL pulse once per press.
  - clr, start and emergency SHALL never auto-repeat.

Verification (DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8)
REQ-026 key_add high for 3 clocks then low -> add stays 0 throughout.
REQ-027 key_add rises at cycle 0 and is held 30 clocks -> add=1 only at cycle 7. With KEY_AUTOREPEAT_EN, add also pulses at cycle 27.
REQ-028 key_start pressed, then key_emg pressed, then key_start pressed again, each with clean 10-clock presses -> start 0->1->0. emergency 0->1, then forced to 0 in the same clock start falls.
REQ-029 key_add and key_clr rise in the same clock and are held -> clr=1 for one clock at cycle 7, add stays 0.
REQ-030 key_add bounces 1,0,1,0, then holds 1 -> exactly one add pulse, 7 clocks after the final rising edge.
REQ-031 nCLR pulled low 2 clocks after key_start has debounced mid-way, while key_start is held -> start=0. After release, start toggles to 1 exactly 7 clocks later.
